i2s_tx_feeder: RTL

//  Sample scheduler in front of I2Stx. Accepts stereo samples from the effect/LFO pipeline over a

---
 rtl/i2s_pkg.sv | 18 +
 rtl/i2s_tx_feeder_if.sv | 13 +
 rtl/stereo_fifo.sv | 60 ++++++
 rtl/i2s_tx_feeder.sv | 133 +++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared types for the I2S transmit feeder: FSM encoding, stereo sample pair,
// and a saturating counter helper.
package i2s_pkg;

  localparam int I2S_WIDTH = 16;

  typedef enum logic [2:0] {IDLE, SYNC, PRIME, RUN, UNDER} feeder_state_t;

  typedef struct packed {
    logic [I2S_WIDTH-1:0] l;
    logic [I2S_WIDTH-1:0] r;
  } stereo_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/i2s_tx_feeder_if.sv
// Upstream stereo sample handshake (valid/ready) between the effect pipeline
// and the I2S transmit feeder.
interface i2s_tx_feeder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_left;
  logic [WIDTH-1:0] in_right;

  modport master (output in_valid, output in_left, output in_right, input in_ready);
  modport slave  (input in_valid, input in_left, input in_right, output in_ready);
endinterface

// File: rtl/stereo_fifo.sv
// Synchronous first-word-fall-through FIFO of packed stereo pairs with flush.
// Pointers carry an extra MSB so full and empty are never ambiguous.
module stereo_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [DW-1:0]            wdata,
  input  logic                     pop,
  output logic [DW-1:0]            rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          do_push, do_pop;

  assign level   = wr_ptr_q - rd_ptr_q;
  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/i2s_tx_feeder.sv
// Buffers upstream stereo pairs and presents one pair per I2S frame, loaded on
// the ws rising edge; handles start-up priming, underrun mute/hold and stats.
module i2s_tx_feeder #(
  parameter int WIDTH         = 16,
  parameter int DEPTH         = 4,
  parameter int PRIME         = 2,
  parameter int UNDERRUN_HOLD = 0
) (
  input  logic                    sclk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    ws,
  i2s_tx_feeder_if.slave          up,
  output logic [WIDTH-1:0]        left_chan,
  output logic [WIDTH-1:0]        right_chan,
  output logic                    underrun,
  output logic [15:0]             underrun_cnt,
  output logic [$clog2(DEPTH):0]  fifo_level
);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] PRIME_LVL = LW'(PRIME);

  i2s_pkg::feeder_state_t state_q, state_d;

  logic             ws_q;
  logic             ld;
  logic             flush, push, pop, und;
  logic             full, empty;
  logic [LW-1:0]    level;
  logic [2*WIDTH-1:0] rdata;
  logic [WIDTH-1:0] left_q, left_d, right_q, right_d;
  logic [15:0]      cnt_q, cnt_d;

  assign ld          = ws & ~ws_q;
  assign flush       = !enable || (state_q == i2s_pkg::IDLE);
  assign up.in_ready = !full && (state_q != i2s_pkg::IDLE);
  assign push        = up.in_valid && up.in_ready;

  stereo_fifo #(
    .DW    (2*WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (sclk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .wdata ({up.in_left, up.in_right}),
    .pop   (pop),
    .rdata (rdata),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) state_q <= i2s_pkg::IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = i2s_pkg::IDLE;
    end else begin
      case (state_q)
        i2s_pkg::IDLE:  state_d = i2s_pkg::SYNC;
        i2s_pkg::SYNC:  if (ld) state_d = i2s_pkg::PRIME;
        i2s_pkg::PRIME: if (ld && level >= PRIME_LVL) state_d = i2s_pkg::RUN;
        i2s_pkg::RUN:   if (ld && empty) state_d = i2s_pkg::UNDER;
        i2s_pkg::UNDER: if (ld && level >= PRIME_LVL) state_d = i2s_pkg::RUN;
        default:        state_d = i2s_pkg::IDLE;
      endcase
    end
  end

  // Pop/underrun decisions use the level before any same-cycle write.
  always_comb begin
    pop = 1'b0;
    und = 1'b0;
    if (enable && ld) begin
      case (state_q)
        i2s_pkg::PRIME: pop = (level >= PRIME_LVL);
        i2s_pkg::RUN: begin
          pop = !empty;
          und = empty;
        end
        i2s_pkg::UNDER: begin
          pop = (level >= PRIME_LVL);
          und = (level < PRIME_LVL);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    left_d  = left_q;
    right_d = right_q;
    cnt_d   = cnt_q;
    if (flush) begin
      left_d  = '0;
      right_d = '0;
    end else if (pop) begin
      left_d  = rdata[2*WIDTH-1:WIDTH];
      right_d = rdata[WIDTH-1:0];
    end else if (und && (UNDERRUN_HOLD == 0)) begin
      left_d  = '0;
      right_d = '0;
    end
    if (und) cnt_d = i2s_pkg::sat_inc16(cnt_q);
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      ws_q    <= 1'b0;
      left_q  <= '0;
      right_q <= '0;
      cnt_q   <= '0;
    end else begin
      ws_q    <= ws;
      left_q  <= left_d;
      right_q <= right_d;
      cnt_q   <= cnt_d;
    end
  end

  assign left_chan    = left_q;
  assign right_chan   = right_q;
  assign underrun     = und;
  assign underrun_cnt = cnt_q;
  assign fifo_level   = level;

endmodule
